// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: hazard-unit control, instruction-memory request/response and IF/ID head.
interface fetch_unit_if;
    logic        PC_Write;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;

    modport master (
        input  PC_Write, redirect, redirect_target, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, if_instr, if_pc4
    );

    modport slave (
        output PC_Write, redirect, redirect_target, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc4
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request feeding a 2-entry {instr, pc4} buffer; head is combinational.
// PC_Write=0 holds the head and stops new requests once two words are buffered; redirect flushes everything.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic [W-1:0]                   push_dat,
    input  logic                           pop,
    output logic [W-1:0]                   head_dat,
    output logic [$clog2(DEPTH):0]         cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_unit (
    input  logic         Clk,
    input  logic         Rst,
    fetch_unit_if.master fif
);
    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] pc_plus4;
    logic        pop, push, flush, req;
    logic [1:0]  cnt;
    logic [1:0]  cnt_pop;
    logic [63:0] head;

    assign pc_plus4 = fetch_pc + 32'd4;
    assign cnt_pop  = cnt - {1'b0, pop};

    fetch_fifo #(.W(64), .DEPTH(2)) u_fifo (
        .clk      (Clk),
        .rst      (Rst),
        .flush    (flush),
        .push     (push),
        .push_dat ({fif.imem_rdata, pc_plus4}),
        .pop      (pop),
        .head_dat (head),
        .cnt      (cnt)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            fetch_pc <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        req          = 1'b0;
        flush        = 1'b0;
        pop          = (cnt != 2'd0) && fif.PC_Write && !fif.redirect;
        if (fif.redirect) begin
            // Pending response in WAIT must still be drained unless it lands this very cycle.
            flush        = 1'b1;
            fetch_pc_nxt = fif.redirect_target & ~32'd3;
            case (state)
                IDLE:    state_nxt = IDLE;
                WAIT:    state_nxt = fif.imem_rvalid ? IDLE : KILL;
                KILL:    state_nxt = fif.imem_rvalid ? IDLE : KILL;
                default: state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (cnt_pop < 2'd2) begin
                        req       = 1'b1;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (fif.imem_rvalid) begin
                        push         = 1'b1;
                        fetch_pc_nxt = pc_plus4;
                        if (cnt_pop == 2'd0) begin
                            req       = 1'b1;
                            state_nxt = WAIT;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                KILL: begin
                    if (fif.imem_rvalid) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A back-to-back request targets the word after the one just returned.
    assign fif.imem_req  = req && !Rst;
    assign fif.imem_addr = Rst ? 32'd0 : ((req && state == WAIT) ? pc_plus4 : fetch_pc);
    assign fif.if_valid  = !Rst && (cnt != 2'd0);
    assign fif.if_instr  = fif.if_valid ? head[63:32] : 32'd0;
    assign fif.if_pc4    = fif.if_valid ? head[31:0]  : 32'd0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    fetch_unit_if fif();

    fetch_unit dut (.Clk(clk), .Rst(rst), .fif(fif));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch address, outstanding/killed flags and a queue of buffered words.
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_kill;
    logic [63:0] m_q[$];

    // Memory environment.
    bit          mem_busy;
    int          mem_cd;
    logic [31:0] mem_a;
    int          mem_lat;
    bit          rand_lat;
    bit          inject;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit pcw, input bit redir, input logic [31:0] tgt);
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        bit          pop;
        int          n_after;
        @(negedge clk);
        rst                 = r;
        fif.PC_Write        = pcw;
        fif.redirect        = redir;
        fif.redirect_target = tgt;
        fif.imem_rvalid     = 1'b0;
        fif.imem_rdata      = $urandom;
        if (r) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cd--;
            if (mem_cd == 0) begin
                fif.imem_rvalid = 1'b1;
                fif.imem_rdata  = mem_word(mem_a);
                mem_busy        = 1'b0;
            end
        end else if (inject) begin
            fif.imem_rvalid = 1'b1;
            fif.imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        e_valid = !r && (m_q.size() > 0);
        e_instr = e_valid ? m_q[0][63:32] : 32'd0;
        e_pc4   = e_valid ? m_q[0][31:0]  : 32'd0;
        pop     = e_valid && pcw && !redir;
        n_after = m_q.size() - int'(pop);
        e_req   = 1'b0;
        e_addr  = r ? 32'd0 : m_pc;
        if (!r && !redir && !m_kill) begin
            if (!m_busy && n_after < 2) begin
                e_req = 1'b1;
            end else if (m_busy && fif.imem_rvalid && n_after + 1 < 2) begin
                e_req  = 1'b1;
                e_addr = m_pc + 32'd4;
            end
        end
        chk("imem_req", fif.imem_req, e_req);
        if (r || e_req || (m_busy && !m_kill)) chk("imem_addr", fif.imem_addr, e_addr);
        chk("if_valid", fif.if_valid, e_valid);
        chk("if_instr", fif.if_instr, e_instr);
        chk("if_pc4",   fif.if_pc4,   e_pc4);
        if (r) begin
            m_pc = 32'd0; m_busy = 0; m_kill = 0; m_q.delete();
        end else if (redir) begin
            m_q.delete();
            m_pc = tgt & ~32'h3;
            if (m_busy) begin
                if (fif.imem_rvalid) begin m_busy = 0; m_kill = 0; end
                else m_kill = 1;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy && fif.imem_rvalid) begin
                if (m_kill) begin
                    m_busy = 0; m_kill = 0;
                end else begin
                    m_q.push_back({fif.imem_rdata, m_pc + 32'd4});
                    m_pc   = m_pc + 32'd4;
                    m_busy = e_req;
                end
            end else if (!m_busy && e_req) begin
                m_busy = 1;
            end
        end
        if (!r && fif.imem_req) begin
            mem_busy = 1'b1;
            mem_a    = fif.imem_addr;
            mem_cd   = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        fif.PC_Write = 1'b1; fif.redirect = 1'b0; fif.redirect_target = '0;
        fif.imem_rvalid = 1'b0; fif.imem_rdata = '0;
        m_pc = '0; m_busy = 0; m_kill = 0;
        mem_busy = 0; mem_cd = 0; mem_a = '0; mem_lat = 1; rand_lat = 0; inject = 0;

        repeat (3) step(1, 1, 0, 0);
        chk("rst_if_valid",  fif.if_valid,  0);
        chk("rst_imem_req",  fif.imem_req,  0);
        chk("rst_imem_addr", fif.imem_addr, 0);

        // Streaming with 1-cycle memory.
        step(0, 1, 0, 0);
        chk("first_req", fif.imem_req, 1);
        chk("first_addr", fif.imem_addr, 32'h0);
        step(0, 1, 0, 0);
        chk("stream_addr4", fif.imem_addr, 32'h4);
        step(0, 1, 0, 0);
        chk("stream_pc4_4", fif.if_pc4, 32'h4);
        chk("stream_addr8", fif.imem_addr, 32'h8);
        step(0, 1, 0, 0);
        chk("stream_pc4_8", fif.if_pc4, 32'h8);
        step(0, 1, 0, 0);
        chk("stream_pc4_12", fif.if_pc4, 32'hC);
        chk("stream_nogap", fif.imem_req, 1);

        // Stall: refill at 0x200 with PC_Write held low.
        step(0, 0, 1, 32'h200);
        chk("redir_no_req", fif.imem_req, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            if (i >= 2) chk("stall_req_low", fif.imem_req, 0);
        end
        chk("stall_pc4_held", fif.if_pc4, 32'h204);
        chk("stall_instr_held", fif.if_instr, mem_word(32'h200));
        step(0, 1, 0, 0);
        chk("release_first", fif.if_pc4, 32'h204);
        step(0, 1, 0, 0);
        chk("release_second", fif.if_pc4, 32'h208);
        chk("release_second_instr", fif.if_instr, mem_word(32'h204));
        step(0, 1, 0, 0);

        // Redirect coinciding with response and pop.
        chk("coincide_valid_before", fif.if_valid, 1);
        step(0, 1, 1, 32'h300);
        chk("coincide_no_req", fif.imem_req, 0);
        step(0, 1, 0, 0);
        chk("coincide_empty", fif.if_valid, 0);
        chk("coincide_addr", fif.imem_addr, 32'h300);

        // Wrap at the top of the address space; low target bits ignored.
        step(0, 1, 1, 32'hFFFF_FFFF);
        step(0, 1, 0, 0);
        chk("wrap_addr_top", fif.imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        chk("wrap_addr_zero", fif.imem_addr, 32'h0);
        step(0, 1, 0, 0);
        chk("wrap_pc4", fif.if_pc4, 32'h0);
        chk("wrap_instr", fif.if_instr, mem_word(32'hFFFF_FFFC));

        // Redirect while a request to 0x8 is outstanding.
        mem_lat = 3;
        repeat (2) step(1, 1, 0, 0);
        step(0, 1, 1, 32'h8);
        step(0, 1, 0, 0);
        chk("kill_setup_addr", fif.imem_addr, 32'h8);
        step(0, 1, 1, 32'h103);
        chk("kill_no_req", fif.imem_req, 0);
        step(0, 1, 0, 0);
        chk("kill_wait_req", fif.imem_req, 0);
        step(0, 1, 0, 0);
        chk("kill_drop_valid", fif.if_valid, 0);
        chk("kill_drop_req", fif.imem_req, 0);
        step(0, 1, 0, 0);
        chk("kill_next_addr", fif.imem_addr, 32'h100);
        repeat (4) step(0, 1, 0, 0);
        chk("kill_pc4", fif.if_pc4, 32'h104);
        chk("kill_instr", fif.if_instr, mem_word(32'h100));

        // Reset mid-request, then a stray response right after release.
        step(1, 1, 0, 0);
        inject = 1;
        step(0, 1, 0, 0);
        inject = 0;
        chk("post_rst_addr", fif.imem_addr, 32'h0);
        mem_lat = 2;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 1, 0, 0);
            if (fif.if_valid) begin
                seen = 1;
                chk("post_rst_pc4", fif.if_pc4, 32'h4);
                chk("post_rst_instr", fif.if_instr, mem_word(32'h0));
            end
        end
        chk("post_rst_seen", 32'(seen), 1);

        // Randomized traffic.
        rand_lat = 1;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            bit          pcw;
            tgt    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            pcw    = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            inject = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 99) == 0, pcw, $urandom_range(0, 15) == 0, tgt);
        end
        inject = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
